// File: rtl/bus_term_ctl_if.sv
// CPU-side bus, decoder selects and fault-record signals for the 68030 cycle terminator.
// The slave modport is the terminator; the master modport is the CPU/decoder side.
interface bus_term_ctl_if #(
    parameter int NCHAN = 4
);
    logic             nAS;
    logic             nDS;
    logic             RnW;
    logic [2:0]       FC;
    logic [31:0]      ADDR;
    logic [NCHAN-1:0] nSEL;
    logic             FAULT_CLR;
    logic [1:0]       DSACK;
    logic             BERR;
    logic             FAULT_VALID;
    logic             FAULT_OVF;
    logic [31:0]      FAULT_ADDR;
    logic [2:0]       FAULT_FC;
    logic             FAULT_RnW;

    modport master (
        output nAS, nDS, RnW, FC, ADDR, nSEL, FAULT_CLR,
        input  DSACK, BERR, FAULT_VALID, FAULT_OVF, FAULT_ADDR, FAULT_FC, FAULT_RnW
    );

    modport slave (
        input  nAS, nDS, RnW, FC, ADDR, nSEL, FAULT_CLR,
        output DSACK, BERR, FAULT_VALID, FAULT_OVF, FAULT_ADDR, FAULT_FC, FAULT_RnW
    );
endinterface

// File: rtl/bus_term_ctl.sv
// 68030 bus-cycle terminator: per-select DSACK with wait states and port size,
// nAS watchdog driving BERR, and a software-visible record of the faulting cycle.
module bus_term_ctl #(
    parameter int                     NCHAN   = 4,
    parameter int                     WAITW   = 4,
    parameter logic [NCHAN*WAITW-1:0] WAITS   = {4'd1, 4'd3, 4'd0, 4'd1},
    parameter logic [NCHAN*2-1:0]     PORTS   = {2'b10, 2'b01, 2'b00, 2'b10},
    parameter int                     TIMEOUT = 64
) (
    input  logic          CPU_CLK,
    input  logic          RESET,
    bus_term_ctl_if.slave bus
);
    localparam int             WDW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_EXT,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [WAITW-1:0]  cnt_q, cnt_d;
    logic [1:0]        port_q, port_d;
    logic [1:0]        dsack_q, dsack_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic              berr_q, berr_d;
    logic              fault_valid_q, fault_valid_d;
    logic              fault_ovf_q, fault_ovf_d;
    logic [31:0]       fault_addr_q, fault_addr_d;
    logic [2:0]        fault_fc_q, fault_fc_d;
    logic              fault_rnw_q, fault_rnw_d;

    logic [WAITW-1:0]  chan_wait [NCHAN];
    logic [1:0]        chan_port [NCHAN];
    logic              sel_found;
    logic [WAITW-1:0]  sel_wait;
    logic [1:0]        sel_port;
    logic              berr_rise;

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        assign chan_wait[gi] = WAITS[gi*WAITW +: WAITW];
        assign chan_port[gi] = PORTS[gi*2 +: 2];
    end

    // Scan from the top so the lowest-numbered asserted select wins.
    always_comb begin
        sel_found = 1'b0;
        sel_wait  = '0;
        sel_port  = 2'b00;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (!bus.nSEL[i]) begin
                sel_found = 1'b1;
                sel_wait  = chan_wait[i];
                sel_port  = chan_port[i];
            end
        end
    end

    always_comb begin
        wd_d   = wd_q;
        berr_d = 1'b0;
        if (bus.nAS) begin
            wd_d = '0;
        end else begin
            if (wd_q != WD_MAX) begin
                wd_d = wd_q + WDW'(1);
            end
            berr_d = berr_q | (wd_q == WD_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        dsack_d = dsack_q;
        case (state_q)
            ST_DRAIN: begin
                if (bus.nAS) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!bus.nAS) begin
                    port_d = sel_port;
                    cnt_d  = sel_wait;
                    if (!sel_found || sel_port == 2'b00) begin
                        state_d = ST_EXT;
                    end else if (sel_wait == '0) begin
                        state_d = ST_ACK;
                        dsack_d = sel_port;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.nAS) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == WAITW'(1)) begin
                    state_d = ST_ACK;
                    dsack_d = port_q;
                end else begin
                    cnt_d = cnt_q - WAITW'(1);
                end
            end
            ST_ACK: begin
                if (bus.nAS) begin
                    state_d = ST_IDLE;
                    dsack_d = 2'b00;
                end
            end
            ST_EXT: begin
                if (bus.nAS) state_d = ST_IDLE;
            end
            default: state_d = ST_DRAIN;
        endcase
        // A timed-out cycle must never be acknowledged, even on the ACK-entry edge.
        if (berr_d) begin
            state_d = ST_DRAIN;
            dsack_d = 2'b00;
        end
    end

    assign berr_rise = berr_d & ~berr_q;

    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_ovf_d   = fault_ovf_q;
        fault_addr_d  = fault_addr_q;
        fault_fc_d    = fault_fc_q;
        fault_rnw_d   = fault_rnw_q;
        if (bus.FAULT_CLR) begin
            fault_valid_d = 1'b0;
            fault_ovf_d   = 1'b0;
        end
        // A clear landing on the same edge as a new fault frees the record for it.
        if (berr_rise) begin
            if (!fault_valid_q || bus.FAULT_CLR) begin
                fault_valid_d = 1'b1;
                fault_ovf_d   = 1'b0;
                fault_addr_d  = bus.ADDR;
                fault_fc_d    = bus.FC;
                fault_rnw_d   = bus.RnW;
            end else begin
                fault_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            state_q       <= ST_DRAIN;
            cnt_q         <= '0;
            port_q        <= 2'b00;
            dsack_q       <= 2'b00;
            wd_q          <= '0;
            berr_q        <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_ovf_q   <= 1'b0;
            fault_addr_q  <= '0;
            fault_fc_q    <= '0;
            fault_rnw_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            dsack_q       <= dsack_d;
            wd_q          <= wd_d;
            berr_q        <= berr_d;
            fault_valid_q <= fault_valid_d;
            fault_ovf_q   <= fault_ovf_d;
            fault_addr_q  <= fault_addr_d;
            fault_fc_q    <= fault_fc_d;
            fault_rnw_q   <= fault_rnw_d;
        end
    end

    // DSACK is gated directly by nDS so it releases in the same cycle the CPU ends the strobe.
    assign bus.DSACK       = dsack_q & {2{~bus.nDS}};
    assign bus.BERR        = berr_q;
    assign bus.FAULT_VALID = fault_valid_q;
    assign bus.FAULT_OVF   = fault_ovf_q;
    assign bus.FAULT_ADDR  = fault_addr_q;
    assign bus.FAULT_FC    = fault_fc_q;
    assign bus.FAULT_RnW   = fault_rnw_q;
endmodule
